// File: rtl/timer_scheduler.sv
// Shares one down-counting timeout engine among N_REQ requesters.
// Round-robin grant, one interval at a time, one-cycle done pulse on completion.
module timer_scheduler #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] len,
  input  logic                   abort,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [ID_W-1:0]        active_id,
  output logic [CNT_W-1:0]       remaining
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [ID_W-1:0]  ptr, ptr_n;
  logic [N_REQ-1:0] gnt_n, done_n;
  logic             busy_n;
  logic [ID_W-1:0]  id_n;
  logic [CNT_W-1:0] rem_n;

  logic             found;
  logic [ID_W-1:0]  pick;
  logic [CNT_W-1:0] pick_len;
  logic [ID_W-1:0]  ptr_inc;
  int               idx;

  // Round-robin scan starting at ptr, wrapping modulo N_REQ.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    pick_len = '0;
    idx      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        pick     = ID_W'(idx);
        pick_len = len[idx*CNT_W +: CNT_W];
      end
    end
  end

  assign ptr_inc = (active_id == ID_W'(N_REQ - 1)) ? '0 : active_id + 1'b1;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt;
    done_n  = '0;
    busy_n  = busy;
    id_n    = active_id;
    rem_n   = remaining;
    case (state)
      IDLE: begin
        gnt_n  = '0;
        busy_n = 1'b0;
        rem_n  = '0;
        if (enable && found) begin
          gnt_n       = '0;
          gnt_n[pick] = 1'b1;
          busy_n      = 1'b1;
          id_n        = pick;
          // A zero-length interval still occupies the engine for one cycle.
          rem_n       = (pick_len == '0) ? CNT_W'(1) : pick_len;
          state_n     = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          gnt_n   = '0;
          busy_n  = 1'b0;
          rem_n   = '0;
          ptr_n   = ptr_inc;
          state_n = IDLE;
        end else if (!enable) begin
          state_n = RUN;
        end else if (remaining == CNT_W'(1)) begin
          gnt_n             = '0;
          busy_n            = 1'b0;
          rem_n             = '0;
          done_n[active_id] = 1'b1;
          ptr_n             = ptr_inc;
          state_n           = IDLE;
        end else begin
          rem_n = remaining - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      active_id <= '0;
      remaining <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gnt       <= gnt_n;
      done      <= done_n;
      busy      <= busy_n;
      active_id <= id_n;
      remaining <= rem_n;
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: hand-computed cycle-by-cycle expectations.
module tb_timer_scheduler;

  localparam int N_REQ = 4;
  localparam int CNT_W = 16;
  localparam int ID_W  = 2;

  logic                   clk;
  logic                   rst_n;
  logic                   enable;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] len;
  logic                   abort;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [ID_W-1:0]        active_id;
  logic [CNT_W-1:0]       remaining;

  int n_tests = 0;
  int n_fail  = 0;
  logic [ID_W-1:0] exp_q[$];

  timer_scheduler #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .len(len), .abort(abort),
    .gnt(gnt), .done(done), .busy(busy), .active_id(active_id), .remaining(remaining)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input logic [CNT_W-1:0] v);
    len[i*CNT_W +: CNT_W] = v;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"},  32'(gnt), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_rem"},  32'(remaining), 32'h0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("rst");
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_id", 32'(active_id), 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; enable = 1'b0; req = '0; len = '0; abort = 1'b0;
    #2;
    apply_reset();

    // 1: single requester, len 5
    enable = 1'b1; set_len(0, 16'd5); req = 4'b0001;
    step();
    req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      chk("t1_gnt", 32'(gnt), 32'h1);
      chk("t1_busy", 32'(busy), 32'h1);
      chk("t1_rem", 32'(remaining), 32'(5 - i));
      chk("t1_done_lo", 32'(done), 32'h0);
      step();
    end
    chk("t1_done", 32'(done), 32'h1);
    chk_idle("t1_end");
    step();
    chk("t1_done_pulse", 32'(done), 32'h0);

    // 2: all request, len 2, order 0,1,2,3,0
    apply_reset();
    for (int i = 0; i < N_REQ; i++) set_len(i, 16'd2);
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req = 4'b1111;
    step();
    while (exp_q.size() > 0) begin
      logic [ID_W-1:0] e;
      e = exp_q.pop_front();
      chk("t2_gnt_a", 32'(gnt), 32'(4'b0001 << e));
      chk("t2_id", 32'(active_id), 32'(e));
      chk("t2_rem_a", 32'(remaining), 32'd2);
      step();
      chk("t2_gnt_b", 32'(gnt), 32'(4'b0001 << e));
      chk("t2_rem_b", 32'(remaining), 32'd1);
      if (exp_q.size() == 0) req = 4'b0000;
      step();
      chk("t2_done", 32'(done), 32'(4'b0001 << e));
      chk("t2_gap_gnt", 32'(gnt), 32'h0);
      step();
    end
    chk("t2_idle", 32'(busy), 32'h0);

    // 3: len 6 with 3-cycle pause
    set_len(0, 16'd6); req = 4'b0001;
    step();
    chk("t3_gnt", 32'(gnt), 32'h1);
    chk("t3_rem6", 32'(remaining), 32'd6);
    req = 4'b0000;
    step(); chk("t3_rem5", 32'(remaining), 32'd5);
    step(); chk("t3_rem4", 32'(remaining), 32'd4);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_hold_rem", 32'(remaining), 32'd4);
      chk("t3_hold_gnt", 32'(gnt), 32'h1);
      chk("t3_hold_done", 32'(done), 32'h0);
    end
    enable = 1'b1;
    step(); chk("t3_rem3", 32'(remaining), 32'd3);
    step(); chk("t3_rem2", 32'(remaining), 32'd2);
    step(); chk("t3_rem1", 32'(remaining), 32'd1);
    step(); chk("t3_done", 32'(done), 32'h1);
    chk_idle("t3_end");

    // 4: abort at remaining 4, next grant to requester 1
    set_len(0, 16'd10); set_len(1, 16'd3); req = 4'b0001;
    step();
    chk("t4_gnt0", 32'(gnt), 32'h1);
    req = 4'b0011;
    for (int r = 9; r >= 4; r--) begin
      step();
      chk("t4_rem", 32'(remaining), 32'(r));
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("t4_abort");
    chk("t4_no_done", 32'(done), 32'h0);
    step();
    chk("t4_gnt1", 32'(gnt), 32'h2);
    chk("t4_id1", 32'(active_id), 32'd1);
    chk("t4_rem1_3", 32'(remaining), 32'd3);
    chk("t4_no_done2", 32'(done), 32'h0);
    req = 4'b0000;
    step(); step(); step();
    chk("t4_done1", 32'(done), 32'h2);

    // 5: len 0 acts as 1; abort in IDLE ignored
    set_len(1, 16'd0); req = 4'b0010;
    step();
    req = 4'b0000;
    chk("t5_gnt1", 32'(gnt), 32'h2);
    chk("t5_rem", 32'(remaining), 32'd1);
    step();
    chk("t5_done1", 32'(done), 32'h2);
    chk("t5_gnt_off", 32'(gnt), 32'h0);
    set_len(2, 16'd2); req = 4'b0100; abort = 1'b1;
    step();
    abort = 1'b0; req = 4'b0000;
    chk("t5_idle_abort_gnt", 32'(gnt), 32'h4);
    chk("t5_idle_abort_rem", 32'(remaining), 32'd2);
    step();
    step();
    chk("t5_done2", 32'(done), 32'h4);

    // 6: async reset mid-RUN, arbitration restarts at 0
    set_len(0, 16'd10); req = 4'b0001;
    step();
    req = 4'b0000;
    step(); step(); step();
    chk("t6_rem7", 32'(remaining), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("t6_async");
    chk("t6_done", 32'(done), 32'h0);
    step();
    chk("t6_done_hold", 32'(done), 32'h0);
    rst_n = 1'b1;
    set_len(3, 16'd2); req = 4'b1001;
    step();
    chk("t6_restart", 32'(gnt), 32'h1);
    chk("t6_restart_id", 32'(active_id), 32'd0);
    req = 4'b0000;
    repeat (12) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // structural invariants checked every cycle on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (!$onehot0(gnt)) chk("inv_gnt_onehot", 32'(gnt), 32'h0);
      if (!$onehot0(done)) chk("inv_done_onehot", 32'(done), 32'h0);
      if ((gnt & done) != '0) chk("inv_gnt_done", 32'(gnt & done), 32'h0);
    end
  end

endmodule
